counter_mod: RTL and testbench

Parametrised up/down modulo counter: the next-generation general counter for the utils library. It adds a programmable step, synchronous load, wrap-vs-saturate mode, a configurable modulus, terminal-count flags and a registered wrap pulse to the basic inc/dec/hold counter. Intended for pointer arithmetic, credit tracking and event/timeout counting across the design.

---
 rtl/counter_mod.sv | 168 ++++++++++++++++
 tb/tb_counter_mod.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/counter_mod.sv
// counter_mod: parametrised up/down modulo counter.
//
// Counts in the range 0..MOD-1 with a programmable step, synchronous load,
// selectable wrap or saturate behaviour, terminal-count flags and a
// registered wrap/clip pulse.
//
// Parameters:
//   W       count width in bits (W >= 2)
//   the modulus, MOD, satisfies 2 <= MOD <= 2**W
//   STEP_W  step input width, (2**STEP_W)-1 <= MOD
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset
//   control_i   2'b00 hold, 2'b01 inc, 2'b10 dec, 2'b11 load
//   step_i      inc/dec magnitude (0 = no change)
//   load_val_i  value captured on load, clamped to MOD-1
//   sat_i       1 = saturate at 0/MOD-1, 0 = wrap modulo MOD
//   prescale_i  inc/dec take effect every (prescale_i+1)-th request
//               (present only when COUNTER_PRESCALE_EN is defined)
//   count_o     registered count
//   wrap_o      registered pulse: last update wrapped or clipped
//   at_max_o    count_o == MOD-1 (combinational)
//   at_min_o    count_o == 0 (combinational)
//
// Optional feature macro: COUNTER_PRESCALE_EN.

module counter_mod #(
  parameter int W      = 8,
  parameter int MOD    = 2**W,
  parameter int STEP_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        control_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [W-1:0]      load_val_i,
  input  logic              sat_i,
`ifdef COUNTER_PRESCALE_EN
  input  logic [7:0]        prescale_i,
`endif
  output logic [W-1:0]      count_o,
  output logic              wrap_o,
  output logic              at_max_o,
  output logic              at_min_o
);

  typedef enum logic [1:0] {
    CTRL_HOLD = 2'b00,
    CTRL_INC  = 2'b01,
    CTRL_DEC  = 2'b10,
    CTRL_LOAD = 2'b11
  } ctrl_e;

  // Arithmetic is done one bit wider than the count so that both the
  // overflow of an increment and the borrow of a decrement are visible.
  localparam logic [W:0]   MOD_X = (W+1)'(MOD);
  localparam logic [W:0]   MAX_X = (W+1)'(MOD - 1);
  localparam logic [W-1:0] MAX_W = W'(MOD - 1);

  if (W < 2 || MOD < 2 || MOD > 2**W || (2**STEP_W) - 1 > MOD) begin : g_bad_params
    $error("counter_mod: illegal parameters W=%0d MOD=%0d STEP_W=%0d", W, MOD, STEP_W);
  end

  ctrl_e        ctrl;
  logic [W-1:0] count_q, count_d;
  logic         wrap_q, wrap_d;
  logic [W:0]   step_x;
  logic [W:0]   sum;
  logic [W:0]   diff;
  logic         advance;

`ifdef COUNTER_PRESCALE_EN
  logic [7:0] presc_q, presc_d;
  // >= rather than == so a prescale_i lowered below the current prescaler
  // value fires at once instead of running the prescaler round to 255.
  assign advance = (presc_q >= prescale_i);
`else
  assign advance = 1'b1;
`endif

  assign ctrl   = ctrl_e'(control_i);
  assign step_x = (W+1)'(step_i);
  assign sum    = {1'b0, count_q} + step_x;
  // diff[W] is the sign bit: the count is always below 2**W, so a negative
  // result can only come from a borrow out of the low W bits.
  assign diff   = {1'b0, count_q} - step_x;

  // NOTE: every variable written here gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    unique case (ctrl)
      CTRL_INC: begin
        if (advance) begin
          if (sum > MAX_X) begin
            if (sat_i) begin
              count_d = MAX_W;
              wrap_d  = (count_q != MAX_W);
            end else begin
              count_d = W'(sum - MOD_X);
              wrap_d  = 1'b1;
            end
          end else begin
            count_d = sum[W-1:0];
          end
        end
      end
      CTRL_DEC: begin
        if (advance) begin
          if (diff[W]) begin
            if (sat_i) begin
              count_d = '0;
              wrap_d  = (count_q != '0);
            end else begin
              count_d = W'(diff + MOD_X);
              wrap_d  = 1'b1;
            end
          end else begin
            count_d = diff[W-1:0];
          end
        end
      end
      CTRL_LOAD: begin
        count_d = ({1'b0, load_val_i} > MAX_X) ? MAX_W : load_val_i;
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

`ifdef COUNTER_PRESCALE_EN
  always_comb begin
    presc_d = presc_q;
    unique case (ctrl)
      CTRL_INC, CTRL_DEC: presc_d = advance ? 8'd0 : presc_q + 8'd1;
      CTRL_LOAD:          presc_d = 8'd0;
      default:            presc_d = presc_q;
    endcase
  end
`endif

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
`ifdef COUNTER_PRESCALE_EN
      presc_q <= 8'd0;
`endif
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
`ifdef COUNTER_PRESCALE_EN
      presc_q <= presc_d;
`endif
    end
  end

  assign count_o  = count_q;
  assign wrap_o   = wrap_q;
  assign at_max_o = (count_q == MAX_W);
  assign at_min_o = (count_q == '0);

endmodule

// File: tb/tb_counter_mod.sv
// Testbench for counter_mod (W=8, MOD=10, STEP_W=3).
// A behavioural model predicts each update; predictions are queued when the
// stimulus is applied and compared once the DUT has clocked it in.

module tb_counter_mod;

  localparam int W      = 8;
  localparam int MOD    = 10;
  localparam int STEP_W = 3;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [1:0]        control_i = 2'b00;
  logic [STEP_W-1:0] step_i = '0;
  logic [W-1:0]      load_val_i = '0;
  logic              sat_i = 1'b0;
  logic [7:0]        prescale_i = 8'd0;
  logic [W-1:0]      count_o;
  logic              wrap_o;
  logic              at_max_o;
  logic              at_min_o;

  counter_mod #(.W(W), .MOD(MOD), .STEP_W(STEP_W)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .control_i  (control_i),
    .step_i     (step_i),
    .load_val_i (load_val_i),
    .sat_i      (sat_i),
`ifdef COUNTER_PRESCALE_EN
    .prescale_i (prescale_i),
`endif
    .count_o    (count_o),
    .wrap_o     (wrap_o),
    .at_max_o   (at_max_o),
    .at_min_o   (at_min_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int count;
    bit wrap;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_count  = 0;
  int   m_presc  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: one clock edge worth of behaviour.
  task automatic model(input bit rst, input int ctrl, input int step,
                       input int ld, input bit sat, output exp_t e);
    int  s;
    bit  w;
    bit  go;
    w = 1'b0;
    if (rst) begin
      m_count = 0;
      m_presc = 0;
    end else if (ctrl == 1 || ctrl == 2) begin
      go = (m_presc == int'(prescale_i));
      m_presc = go ? 0 : m_presc + 1;
      if (go) begin
        s = (ctrl == 1) ? m_count + step : m_count - step;
        if (s >= MOD) begin
          w       = sat ? (m_count != MOD - 1) : 1'b1;
          m_count = sat ? MOD - 1 : s - MOD;
        end else if (s < 0) begin
          w       = sat ? (m_count != 0) : 1'b1;
          m_count = sat ? 0 : s + MOD;
        end else begin
          m_count = s;
        end
      end
    end else if (ctrl == 3) begin
      m_count = (ld > MOD - 1) ? MOD - 1 : ld;
      m_presc = 0;
    end
    e.count = m_count;
    e.wrap  = w;
  endtask

  // Apply one cycle of stimulus, queue the prediction, compare after the edge.
  task automatic drive(input bit rst, input int ctrl, input int step,
                       input int ld, input bit sat);
    exp_t e;
    @(negedge clk_i);
    rst_i      = rst;
    control_i  = 2'(ctrl);
    step_i     = STEP_W'(step);
    load_val_i = W'(ld);
    sat_i      = sat;
    model(rst, ctrl, step, ld, sat, e);
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    e = sb_q.pop_front();
    check("count",  int'(count_o),  e.count);
    check("wrap",   int'(wrap_o),   int'(e.wrap));
    check("at_max", int'(at_max_o), int'(e.count == MOD - 1));
    check("at_min", int'(at_min_o), int'(e.count == 0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with INC requested.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1, 1, 0, 1'b0);
      check("rst_at_min", int'(at_min_o), 1);
    end

    // Wrap up.
    drive(1'b0, 3, 0, 8, 1'b0);
    drive(1'b0, 1, 3, 0, 1'b0);
    check("wrapup_cnt", int'(count_o), 1);
    check("wrapup_wrap", int'(wrap_o), 1);
    drive(1'b0, 1, 1, 0, 1'b0);
    check("wrapup_next", int'(count_o), 2);
    check("wrapup_nowrap", int'(wrap_o), 0);

    // Wrap down, then saturate down.
    drive(1'b0, 3, 0, 1, 1'b0);
    drive(1'b0, 2, 3, 0, 1'b0);
    check("wrapdn_cnt", int'(count_o), 8);
    check("wrapdn_wrap", int'(wrap_o), 1);
    drive(1'b0, 3, 0, 1, 1'b1);
    drive(1'b0, 2, 3, 0, 1'b1);
    check("satdn_cnt", int'(count_o), 0);
    check("satdn_wrap", int'(wrap_o), 1);
    drive(1'b0, 2, 3, 0, 1'b1);
    check("satdn_pinned", int'(wrap_o), 0);

    // Load clamp, step 0, saturate up while pinned, then back-to-back wraps.
    drive(1'b0, 3, 5, 200, 1'b0);
    check("clamp_cnt", int'(count_o), 9);
    check("clamp_max", int'(at_max_o), 1);
    drive(1'b0, 1, 0, 0, 1'b0);
    check("step0_hold", int'(count_o), 9);
    drive(1'b0, 1, 1, 0, 1'b1);
    drive(1'b0, 1, 1, 0, 1'b0);
    drive(1'b0, 2, 1, 0, 1'b0);
    check("b2b_wrap", int'(wrap_o), 1);
    drive(1'b0, 1, 1, 0, 1'b0);
    drive(1'b0, 0, 7, 0, 1'b0);

    // Mid-operation reset at count 5.
    drive(1'b0, 3, 0, 0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1, 1, 0, 1'b0);
    check("pre_rst_cnt", int'(count_o), 5);
    drive(1'b1, 1, 1, 0, 1'b0);
    check("mid_rst_cnt", int'(count_o), 0);
    drive(1'b0, 1, 1, 0, 1'b0);
    drive(1'b0, 1, 1, 0, 1'b0);
    check("post_rst_cnt", int'(count_o), 2);

    // Random mix of all codes, modes and occasional resets.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 24) == 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            bit'($urandom_range(0, 1)));
    end

`ifdef COUNTER_PRESCALE_EN
    // Prescale 2: increments after request cycles 3, 6 and 9.
    drive(1'b1, 0, 0, 0, 1'b0);
    prescale_i = 8'd2;
    for (int i = 0; i < 9; i++) drive(1'b0, 1, 1, 0, 1'b0);
    check("presc_cnt", int'(count_o), 3);
    // Hold cycles interleaved must not advance the prescaler.
    for (int i = 0; i < 60; i++) begin
      drive(1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
    end
    prescale_i = 8'd0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
